pulse_register_bank: RTL and testbench

Multi-channel, double-buffered successor to the single-channel pulse parameter register, with per-channel playback sequencing. Software writes each channel's amplitude, phase, frequency, start time and length into a shadow set over a narrow addressed port; a masked commit copies shadow to active atomically and arms the channel. A free-running time base then drives each armed channel through its pulse window, producing per-channel `pulse_on`/`pulse_done` for the downstream NCO/DAC path.

---
 rtl/pulse_register_bank.sv | 233 +++++++++++++++++++++++
 tb/tb_pulse_register_bank.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_register_bank.sv
// Multi-channel double-buffered pulse parameter bank with start/length playback sequencing.
// Defining PULSE_BANK_READBACK_EN adds a registered 1-cycle shadow/active readback port.
module pulse_register_bank #(
  parameter int NUM_CH   = 4,
  parameter int AMP_W    = 14,
  parameter int PHASE_W  = 16,
  parameter int FREQ_W   = 32,
  parameter int TSTART_W = 28,
  parameter int TLEN_W   = 20,
  parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [CH_W-1:0]              wr_ch,
  input  logic [2:0]                   wr_field,
  input  logic [31:0]                  wr_data,
  input  logic                         commit,
  input  logic [NUM_CH-1:0]            commit_mask,
  input  logic                         time_run,
  input  logic                         time_clr,
  output logic [TSTART_W-1:0]          time_now,
  output logic [NUM_CH*AMP_W-1:0]      amplitude,
  output logic [NUM_CH*PHASE_W-1:0]    phase,
  output logic [NUM_CH*FREQ_W-1:0]     frequency,
  output logic [NUM_CH*TSTART_W-1:0]   t_start,
  output logic [NUM_CH*TLEN_W-1:0]     t_len,
  output logic [NUM_CH-1:0]            pulse_on,
  output logic [NUM_CH-1:0]            pulse_done,
  output logic [NUM_CH-1:0]            armed
`ifdef PULSE_BANK_READBACK_EN
  ,
  input  logic [CH_W-1:0]              rd_ch,
  input  logic [2:0]                   rd_field,
  input  logic                         rd_shadow,
  output logic [31:0]                  rd_data
`endif
);

  localparam logic [2:0] F_AMP   = 3'd0;
  localparam logic [2:0] F_PHASE = 3'd1;
  localparam logic [2:0] F_FREQ  = 3'd2;
  localparam logic [2:0] F_TSTRT = 3'd3;
  localparam logic [2:0] F_TLEN  = 3'd4;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PLAY} state_e;

  logic [AMP_W-1:0]    sh_amp_q   [NUM_CH];
  logic [AMP_W-1:0]    sh_amp_d   [NUM_CH];
  logic [PHASE_W-1:0]  sh_phase_q [NUM_CH];
  logic [PHASE_W-1:0]  sh_phase_d [NUM_CH];
  logic [FREQ_W-1:0]   sh_freq_q  [NUM_CH];
  logic [FREQ_W-1:0]   sh_freq_d  [NUM_CH];
  logic [TSTART_W-1:0] sh_tstrt_q [NUM_CH];
  logic [TSTART_W-1:0] sh_tstrt_d [NUM_CH];
  logic [TLEN_W-1:0]   sh_tlen_q  [NUM_CH];
  logic [TLEN_W-1:0]   sh_tlen_d  [NUM_CH];

  logic [AMP_W-1:0]    act_amp_q   [NUM_CH];
  logic [AMP_W-1:0]    act_amp_d   [NUM_CH];
  logic [PHASE_W-1:0]  act_phase_q [NUM_CH];
  logic [PHASE_W-1:0]  act_phase_d [NUM_CH];
  logic [FREQ_W-1:0]   act_freq_q  [NUM_CH];
  logic [FREQ_W-1:0]   act_freq_d  [NUM_CH];
  logic [TSTART_W-1:0] act_tstrt_q [NUM_CH];
  logic [TSTART_W-1:0] act_tstrt_d [NUM_CH];
  logic [TLEN_W-1:0]   act_tlen_q  [NUM_CH];
  logic [TLEN_W-1:0]   act_tlen_d  [NUM_CH];

  state_e              state_q [NUM_CH];
  state_e              state_d [NUM_CH];
  logic [TLEN_W-1:0]   rem_q   [NUM_CH];
  logic [TLEN_W-1:0]   rem_d   [NUM_CH];
  logic [NUM_CH-1:0]   done_q, done_d;
  logic [TSTART_W-1:0] time_q, time_d;

  // Shadow write port; channels beyond NUM_CH never match, so they are ignored.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sh_amp_d[i]   = sh_amp_q[i];
      sh_phase_d[i] = sh_phase_q[i];
      sh_freq_d[i]  = sh_freq_q[i];
      sh_tstrt_d[i] = sh_tstrt_q[i];
      sh_tlen_d[i]  = sh_tlen_q[i];
      if (wr_en && (wr_ch == CH_W'(i))) begin
        case (wr_field)
          F_AMP:   sh_amp_d[i]   = wr_data[AMP_W-1:0];
          F_PHASE: sh_phase_d[i] = wr_data[PHASE_W-1:0];
          F_FREQ:  sh_freq_d[i]  = wr_data[FREQ_W-1:0];
          F_TSTRT: sh_tstrt_d[i] = wr_data[TSTART_W-1:0];
          F_TLEN:  sh_tlen_d[i]  = wr_data[TLEN_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    time_d = time_q;
    if (time_clr) begin
      time_d = '0;
    end else if (time_run) begin
      time_d = time_q + TSTART_W'(1);
    end
  end

  // Commit sees the pre-write shadow and overrides any playback in progress.
  always_comb begin
    done_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]     = state_q[i];
      rem_d[i]       = rem_q[i];
      act_amp_d[i]   = act_amp_q[i];
      act_phase_d[i] = act_phase_q[i];
      act_freq_d[i]  = act_freq_q[i];
      act_tstrt_d[i] = act_tstrt_q[i];
      act_tlen_d[i]  = act_tlen_q[i];
      if (commit && commit_mask[i]) begin
        act_amp_d[i]   = sh_amp_q[i];
        act_phase_d[i] = sh_phase_q[i];
        act_freq_d[i]  = sh_freq_q[i];
        act_tstrt_d[i] = sh_tstrt_q[i];
        act_tlen_d[i]  = sh_tlen_q[i];
        state_d[i]     = ST_ARMED;
        rem_d[i]       = '0;
      end else begin
        case (state_q[i])
          ST_ARMED: begin
            if (time_q == act_tstrt_q[i]) begin
              if (act_tlen_q[i] != '0) begin
                state_d[i] = ST_PLAY;
                rem_d[i]   = act_tlen_q[i];
              end else begin
                state_d[i] = ST_IDLE;
                done_d[i]  = 1'b1;
              end
            end
          end
          ST_PLAY: begin
            rem_d[i] = rem_q[i] - TLEN_W'(1);
            if (rem_q[i] == TLEN_W'(1)) begin
              state_d[i] = ST_IDLE;
              done_d[i]  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q <= '0;
      done_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_amp_q[i]    <= '0;
        sh_phase_q[i]  <= '0;
        sh_freq_q[i]   <= '0;
        sh_tstrt_q[i]  <= '0;
        sh_tlen_q[i]   <= '0;
        act_amp_q[i]   <= '0;
        act_phase_q[i] <= '0;
        act_freq_q[i]  <= '0;
        act_tstrt_q[i] <= '0;
        act_tlen_q[i]  <= '0;
        state_q[i]     <= ST_IDLE;
        rem_q[i]       <= '0;
      end
    end else begin
      time_q <= time_d;
      done_q <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_amp_q[i]    <= sh_amp_d[i];
        sh_phase_q[i]  <= sh_phase_d[i];
        sh_freq_q[i]   <= sh_freq_d[i];
        sh_tstrt_q[i]  <= sh_tstrt_d[i];
        sh_tlen_q[i]   <= sh_tlen_d[i];
        act_amp_q[i]   <= act_amp_d[i];
        act_phase_q[i] <= act_phase_d[i];
        act_freq_q[i]  <= act_freq_d[i];
        act_tstrt_q[i] <= act_tstrt_d[i];
        act_tlen_q[i]  <= act_tlen_d[i];
        state_q[i]     <= state_d[i];
        rem_q[i]       <= rem_d[i];
      end
    end
  end

  assign time_now   = time_q;
  assign pulse_done = done_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign amplitude[g*AMP_W +: AMP_W]      = act_amp_q[g];
    assign phase[g*PHASE_W +: PHASE_W]      = act_phase_q[g];
    assign frequency[g*FREQ_W +: FREQ_W]    = act_freq_q[g];
    assign t_start[g*TSTART_W +: TSTART_W]  = act_tstrt_q[g];
    assign t_len[g*TLEN_W +: TLEN_W]        = act_tlen_q[g];
    assign pulse_on[g]                      = (state_q[g] == ST_PLAY);
    assign armed[g]                         = (state_q[g] == ST_ARMED);
  end

`ifdef PULSE_BANK_READBACK_EN
  logic [31:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) begin
        case (rd_field)
          F_AMP:   rd_data_d = 32'(rd_shadow ? sh_amp_q[i]   : act_amp_q[i]);
          F_PHASE: rd_data_d = 32'(rd_shadow ? sh_phase_q[i] : act_phase_q[i]);
          F_FREQ:  rd_data_d = 32'(rd_shadow ? sh_freq_q[i]  : act_freq_q[i]);
          F_TSTRT: rd_data_d = 32'(rd_shadow ? sh_tstrt_q[i] : act_tstrt_q[i]);
          F_TLEN:  rd_data_d = 32'(rd_shadow ? sh_tlen_q[i]  : act_tlen_q[i]);
          default: rd_data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_pulse_register_bank.sv
// Randomized bench for pulse_register_bank against a window-based reference model, plus directed pins.
module tb_pulse_register_bank;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [1:0]   wr_ch;
  logic [2:0]   wr_field;
  logic [31:0]  wr_data;
  logic         commit;
  logic [3:0]   commit_mask;
  logic         time_run;
  logic         time_clr;
  logic [27:0]  time_now;
  logic [55:0]  amplitude;
  logic [63:0]  phase;
  logic [127:0] frequency;
  logic [111:0] t_start;
  logic [79:0]  t_len;
  logic [3:0]   pulse_on;
  logic [3:0]   pulse_done;
  logic [3:0]   armed;
`ifdef PULSE_BANK_READBACK_EN
  logic [1:0]   rd_ch;
  logic [2:0]   rd_field;
  logic         rd_shadow;
  logic [31:0]  rd_data;
  logic [31:0]  m_rd;
`endif

  pulse_register_bank dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_field(wr_field),
    .wr_data(wr_data), .commit(commit), .commit_mask(commit_mask), .time_run(time_run),
    .time_clr(time_clr), .time_now(time_now), .amplitude(amplitude), .phase(phase),
    .frequency(frequency), .t_start(t_start), .t_len(t_len), .pulse_on(pulse_on),
    .pulse_done(pulse_done), .armed(armed)
`ifdef PULSE_BANK_READBACK_EN
    , .rd_ch(rd_ch), .rd_field(rd_field), .rd_shadow(rd_shadow), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: parameter sets plus absolute-cycle playback windows.
  logic [31:0] m_sh  [NC][5];
  logic [31:0] m_act [NC][5];
  bit          m_armed [NC];
  longint      m_on_from [NC];
  longint      m_on_to [NC];
  longint      m_done_at [NC];
  logic [27:0] m_time;
  longint      cyc;

  function automatic int fw(int f);
    case (f)
      0: return 14;
      1: return 16;
      2: return 32;
      3: return 28;
      default: return 20;
    endcase
  endfunction

  function automatic logic [31:0] fmask(logic [31:0] v, int f);
    logic [63:0] m;
    m = (64'd1 << fw(f)) - 64'd1;
    return v & m[31:0];
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      for (int f = 0; f < 5; f++) begin
        m_sh[c][f]  = '0;
        m_act[c][f] = '0;
      end
      m_armed[c]   = 1'b0;
      m_on_from[c] = -1;
      m_on_to[c]   = -2;
      m_done_at[c] = -1;
    end
    m_time = '0;
`ifdef PULSE_BANK_READBACK_EN
    m_rd = '0;
`endif
  endtask

  task automatic model_step();
    int tl;
`ifdef PULSE_BANK_READBACK_EN
    m_rd = '0;
    if (rd_field < 5) m_rd = rd_shadow ? m_sh[rd_ch][rd_field] : m_act[rd_ch][rd_field];
`endif
    for (int c = 0; c < NC; c++) begin
      if (commit && commit_mask[c]) begin
        for (int f = 0; f < 5; f++) m_act[c][f] = m_sh[c][f];
        m_armed[c]   = 1'b1;
        m_on_from[c] = -1;
        m_on_to[c]   = -2;
        m_done_at[c] = -1;
      end else if (m_armed[c] && (m_time == m_act[c][3][27:0])) begin
        m_armed[c] = 1'b0;
        tl = int'(m_act[c][4]);
        if (tl != 0) begin
          m_on_from[c] = cyc + 1;
          m_on_to[c]   = cyc + tl;
        end
        m_done_at[c] = cyc + tl + 1;
      end
    end
    if (wr_en && wr_field < 5) m_sh[wr_ch][wr_field] = fmask(wr_data, int'(wr_field));
    if (time_clr) m_time = '0;
    else if (time_run) m_time = m_time + 28'd1;
    cyc++;
  endtask

  task automatic compare_all();
    logic [55:0]  e_amp;
    logic [63:0]  e_ph;
    logic [127:0] e_fr;
    logic [111:0] e_ts;
    logic [79:0]  e_tl;
    logic [3:0]   e_on, e_done, e_arm;
    for (int c = 0; c < NC; c++) begin
      e_amp[c*14 +: 14] = m_act[c][0][13:0];
      e_ph[c*16 +: 16]  = m_act[c][1][15:0];
      e_fr[c*32 +: 32]  = m_act[c][2];
      e_ts[c*28 +: 28]  = m_act[c][3][27:0];
      e_tl[c*20 +: 20]  = m_act[c][4][19:0];
      e_on[c]   = (cyc >= m_on_from[c]) && (cyc <= m_on_to[c]);
      e_done[c] = (m_done_at[c] == cyc);
      e_arm[c]  = m_armed[c];
    end
    chk("time_now", time_now, m_time);
    chk("amplitude", amplitude, e_amp);
    chk("phase", phase, e_ph);
    chk("frequency", frequency, e_fr);
    chk("t_start", t_start, e_ts);
    chk("t_len", t_len, e_tl);
    chk("pulse_on", pulse_on, e_on);
    chk("pulse_done", pulse_done, e_done);
    chk("armed", armed, e_arm);
`ifdef PULSE_BANK_READBACK_EN
    chk("rd_data", rd_data, m_rd);
`endif
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge after checking.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_in();
    wr_en = 1'b0; wr_ch = '0; wr_field = '0; wr_data = '0;
    commit = 1'b0; commit_mask = '0; time_run = 1'b0; time_clr = 1'b0;
`ifdef PULSE_BANK_READBACK_EN
    rd_ch = '0; rd_field = '0; rd_shadow = 1'b0;
`endif
  endtask

  task automatic wr(int ch, int f, logic [31:0] d);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_field = 3'(f); wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic commit_clr(logic [3:0] m);
    commit = 1'b1; commit_mask = m; time_clr = 1'b1;
    cycle();
    commit = 1'b0; commit_mask = '0; time_clr = 1'b0; time_run = 1'b1;
  endtask

  initial begin
    cyc = 0;
    idle_in();
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Idle after reset, time base held.
    repeat (10) cycle();
    chk("rst_time", time_now, 28'd0);
    chk("rst_outs", {pulse_on, pulse_done, armed}, 12'd0);
    chk("rst_amp", amplitude, 56'd0);

    // Ch2 basic pulse: start 5, length 3.
    wr(2, 0, 32'h0000_1ABC);
    wr(2, 3, 32'd5);
    wr(2, 4, 32'd3);
    commit_clr(4'b0100);
    chk("t2_armed", armed[2], 1'b1);
    chk("t2_amp2", amplitude[28 +: 14], 14'h1ABC);
    chk("t2_amp_oth", amplitude & ~(56'h3FFF << 28), 56'd0);
    for (int tn = 1; tn <= 12; tn++) begin
      cycle();
      chk("t2_time", time_now, 28'(tn));
      chk("t2_on", pulse_on[2], (tn >= 6 && tn <= 8));
      chk("t2_done", pulse_done[2], (tn == 9));
    end

    // Ch0 zero-length pulse: strobe only.
    wr(0, 3, 32'd2);
    wr(0, 4, 32'd0);
    commit_clr(4'b0001);
    for (int tn = 1; tn <= 8; tn++) begin
      cycle();
      chk("t3_on", pulse_on[0], 1'b0);
      chk("t3_done", pulse_done[0], (tn == 3));
    end

    // Ch1 long pulse aborted by re-commit.
    wr(1, 3, 32'd1);
    wr(1, 4, 32'd100);
    commit_clr(4'b0010);
    repeat (11) cycle();
    chk("t4_playing", pulse_on[1], 1'b1);
    commit = 1'b1; commit_mask = 4'b0010;
    cycle();
    commit = 1'b0; commit_mask = '0;
    chk("t4_on_drop", pulse_on[1], 1'b0);
    chk("t4_armed", armed[1], 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("t4_no_done", pulse_done[1], 1'b0);
      cycle();
    end

    // Same-cycle write and commit on ch3.
    wr(3, 1, 32'h0000_0010);
    wr_en = 1'b1; wr_ch = 2'd3; wr_field = 3'd1; wr_data = 32'h0000_1234;
    commit = 1'b1; commit_mask = 4'b1000;
    cycle();
    wr_en = 1'b0;
    chk("t5_first", phase[48 +: 16], 16'h0010);
    cycle();
    commit = 1'b0; commit_mask = '0;
    chk("t5_second", phase[48 +: 16], 16'h1234);
`ifdef PULSE_BANK_READBACK_EN
    rd_ch = 2'd3; rd_field = 3'd1; rd_shadow = 1'b1;
    cycle();
    chk("t6_rd", rd_data, 32'h1234);
    rd_field = 3'd6;
    cycle();
    chk("t6_rd_inv", rd_data, 32'd0);
`endif

    // Asynchronous reset in the middle of a pulse.
    wr(0, 3, 32'd3);
    wr(0, 4, 32'd20);
    commit_clr(4'b0001);
    repeat (6) cycle();
    chk("t7_playing", pulse_on[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_outs", {pulse_on, pulse_done, armed}, 12'd0);
    chk("t7_rst_time", time_now, 28'd0);
    model_reset();
    idle_in();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      wr_en    = ($urandom_range(0, 2) != 0);
      wr_ch    = 2'($urandom_range(0, 3));
      wr_field = 3'($urandom_range(0, 7));
      wr_data  = $urandom;
      if (wr_field == 3'd3) wr_data = (wr_data & 32'hF000_0000) | $urandom_range(0, 40);
      if (wr_field == 3'd4) wr_data = (wr_data & 32'hFFF0_0000) | $urandom_range(0, 12);
      commit      = ($urandom_range(0, 9) == 0);
      commit_mask = 4'($urandom);
      time_run    = ($urandom_range(0, 7) != 0);
      time_clr    = ($urandom_range(0, 49) == 0);
`ifdef PULSE_BANK_READBACK_EN
      rd_ch     = 2'($urandom_range(0, 3));
      rd_field  = 3'($urandom_range(0, 7));
      rd_shadow = 1'($urandom);
`endif
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
